// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP receive parser.
// No logic; no latency.
// No flow control of its own.
package udp_pkg;

    typedef enum logic [7:0] {
        IDLE = 8'h00,
        HDR  = 8'h01,
        DATA = 8'h02,
        DROP = 8'h03,
        DONE = 8'h04
    } state_t;

    localparam int UDP_HDR_LEN = 8;

    localparam logic [2:0] OFS_SRC_HI  = 3'd0;
    localparam logic [2:0] OFS_SRC_LO  = 3'd1;
    localparam logic [2:0] OFS_DST_HI  = 3'd2;
    localparam logic [2:0] OFS_DST_LO  = 3'd3;
    localparam logic [2:0] OFS_LEN_HI  = 3'd4;
    localparam logic [2:0] OFS_LEN_LO  = 3'd5;
    localparam logic [2:0] OFS_CSUM_HI = 3'd6;
    localparam logic [2:0] OFS_CSUM_LO = 3'd7;

    localparam int ERR_PORT  = 0;
    localparam int ERR_LEN   = 1;
    localparam int ERR_OVF   = 2;
    localparam int ERR_TRUNC = 3;

    function automatic logic [15:0] be16(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/udp_rx_filt_sat_cnt.sv
// Saturating event counter: sticks at all-ones, synchronous clear.
// Count visible 1 cycle after inc.
// No backpressure; increments past saturation are ignored.
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/udp_rx_filt.sv
// UDP header parser with dst-port filter, length check, overflow/truncation flags, stats.
// Payload appears on fifo_txen/fifo_txd 1 cycle after rxd; fd 1 cycle after last byte.
// fifo_full cannot stall the stream: the byte it gates and the rest of the frame are discarded.
module udp_rx_filt
    import udp_pkg::*;
#(
    parameter logic [15:0] LOCAL_PORT = 16'h1F90,
    parameter bit          PORT_FILT  = 1'b1,
    parameter int          MAX_DLEN   = 1472,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fs,
    input  logic [7:0]       rxd,
    input  logic             fifo_full,
    output logic             fd,
    output logic [15:0]      dlen,
    output logic [15:0]      src_ip_port,
    output logic [15:0]      det_ip_port,
    output logic             fifo_txen,
    output logic [7:0]       fifo_txd,
    output logic [3:0]       err,
    output logic [CNT_W-1:0] frm_ok_cnt,
    output logic [CNT_W-1:0] frm_drop_cnt
);

    state_t      state;
    logic [2:0]  hdr_cnt;
    logic [15:0] pay_cnt;
    logic [7:0]  len_hi;
    logic        len_bad;
    logic        ok_inc;
    logic        drop_inc;

    logic [15:0] len_fld;
    logic [15:0] dlen_calc;
    logic [15:0] dst_fld;
    logic        last_pay;
    logic        ovf_now;

    assign len_fld   = be16(len_hi, rxd);
    assign dlen_calc = len_fld - 16'(UDP_HDR_LEN);
    assign dst_fld   = be16(det_ip_port[15:8], rxd);
    assign last_pay  = (pay_cnt == (dlen - 16'd1));
    assign ovf_now   = fifo_full | err[ERR_OVF];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            hdr_cnt     <= 3'd0;
            pay_cnt     <= 16'd0;
            len_hi      <= 8'd0;
            len_bad     <= 1'b0;
            ok_inc      <= 1'b0;
            drop_inc    <= 1'b0;
            fd          <= 1'b0;
            dlen        <= 16'd0;
            src_ip_port <= 16'd0;
            det_ip_port <= 16'd0;
            fifo_txen   <= 1'b0;
            fifo_txd    <= 8'd0;
            err         <= 4'd0;
        end else begin
            fifo_txen <= 1'b0;
            ok_inc    <= 1'b0;
            drop_inc  <= 1'b0;

            case (state)
                IDLE: begin
                    fd <= 1'b0;
                    if (fs) begin
                        state       <= HDR;
                        hdr_cnt     <= OFS_SRC_LO;
                        src_ip_port <= be16(rxd, 8'd0);
                        det_ip_port <= 16'd0;
                        dlen        <= 16'd0;
                        err         <= 4'd0;
                        len_bad     <= 1'b0;
                        pay_cnt     <= 16'd0;
                    end
                end

                HDR: begin
                    if (!fs) begin
                        err[ERR_TRUNC] <= 1'b1;
                        drop_inc       <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        hdr_cnt <= hdr_cnt + 3'd1;
                        case (hdr_cnt)
                            OFS_SRC_LO: src_ip_port[7:0] <= rxd;
                            OFS_DST_HI: det_ip_port[15:8] <= rxd;
                            OFS_DST_LO: begin
                                det_ip_port[7:0] <= rxd;
                                if (PORT_FILT && (dst_fld != LOCAL_PORT)) begin
                                    err[ERR_PORT] <= 1'b1;
                                end
                            end
                            OFS_LEN_HI: len_hi <= rxd;
                            OFS_LEN_LO: begin
                                // dlen is only derived once the field is known to cover the header
                                if (len_fld < 16'(UDP_HDR_LEN)) begin
                                    err[ERR_LEN] <= 1'b1;
                                    len_bad      <= 1'b1;
                                end else begin
                                    dlen <= dlen_calc;
                                    if (dlen_calc > 16'(MAX_DLEN)) begin
                                        err[ERR_LEN] <= 1'b1;
                                        len_bad      <= 1'b1;
                                    end
                                end
                            end
                            OFS_CSUM_LO: begin
                                if (err != 4'd0) begin
                                    // an errored frame with no payload has nothing left to drain
                                    if (len_bad || (dlen != 16'd0)) begin
                                        state <= DROP;
                                    end else begin
                                        state    <= DONE;
                                        fd       <= 1'b1;
                                        drop_inc <= 1'b1;
                                    end
                                end else if (dlen == 16'd0) begin
                                    state  <= DONE;
                                    fd     <= 1'b1;
                                    ok_inc <= 1'b1;
                                end else begin
                                    state <= DATA;
                                end
                            end
                            OFS_SRC_HI, OFS_CSUM_HI: ;
                            default: ;
                        endcase
                    end
                end

                DATA: begin
                    if (!fs) begin
                        err[ERR_TRUNC] <= 1'b1;
                        drop_inc       <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        pay_cnt <= pay_cnt + 16'd1;
                        if (ovf_now) begin
                            err[ERR_OVF] <= 1'b1;
                        end else begin
                            fifo_txen <= 1'b1;
                            fifo_txd  <= rxd;
                        end
                        if (last_pay) begin
                            state    <= DONE;
                            fd       <= 1'b1;
                            ok_inc   <= ~ovf_now;
                            drop_inc <= ovf_now;
                        end
                    end
                end

                DROP: begin
                    if (len_bad) begin
                        // the length field cannot be trusted, so the frame ends when fs falls
                        if (!fs) begin
                            state    <= DONE;
                            fd       <= 1'b1;
                            drop_inc <= 1'b1;
                        end
                    end else if (!fs) begin
                        err[ERR_TRUNC] <= 1'b1;
                        drop_inc       <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        pay_cnt <= pay_cnt + 16'd1;
                        if (last_pay) begin
                            state    <= DONE;
                            fd       <= 1'b1;
                            drop_inc <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    fd <= 1'b1;
                    if (!fs) begin
                        state <= IDLE;
                        fd    <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    sat_cnt #(.W(CNT_W)) u_ok_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ok_inc),
        .clear (1'b0),
        .cnt   (frm_ok_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc),
        .clear (1'b0),
        .cnt   (frm_drop_cnt)
    );

endmodule

// File: tb/tb_udp_rx_filt.sv
// Bench for udp_rx_filt: one filtering and one promiscuous instance share the byte stream,
// each checked against a frame-level reference model.
module tb_udp_rx_filt;

    localparam logic [15:0] LP   = 16'h1F90;
    localparam int          MAXD = 1472;
    localparam int          BIG  = 100000;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        fs        = 1'b0;
    logic [7:0]  rxd       = 8'd0;
    logic        fifo_full = 1'b0;

    logic        fd0, fd1, txen0, txen1;
    logic [7:0]  txd0, txd1;
    logic [15:0] dlen0, dlen1, src0, src1, det0, det1, ok0, ok1, drop0, drop1;
    logic [3:0]  err0, err1;

    udp_rx_filt #(.LOCAL_PORT(LP), .PORT_FILT(1'b1), .MAX_DLEN(MAXD), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .fs(fs), .rxd(rxd), .fifo_full(fifo_full),
        .fd(fd0), .dlen(dlen0), .src_ip_port(src0), .det_ip_port(det0),
        .fifo_txen(txen0), .fifo_txd(txd0), .err(err0),
        .frm_ok_cnt(ok0), .frm_drop_cnt(drop0)
    );

    udp_rx_filt #(.LOCAL_PORT(LP), .PORT_FILT(1'b0), .MAX_DLEN(MAXD), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .fs(fs), .rxd(rxd), .fifo_full(fifo_full),
        .fd(fd1), .dlen(dlen1), .src_ip_port(src1), .det_ip_port(det1),
        .fifo_txen(txen1), .fifo_txd(txd1), .err(err1),
        .frm_ok_cnt(ok1), .frm_drop_cnt(drop1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ok_m   [2];
    int drop_m [2];

    logic [15:0] f_src, f_dst, f_len;
    int          f_npay, f_full, f_gap;
    logic [7:0]  cur_pay [$];

    logic [7:0]  wq0 [$];
    logic [7:0]  wq1 [$];
    int          fdc0 = 0;
    int          fdc1 = 0;

    always @(negedge clk) begin
        if (txen0) wq0.push_back(txd0);
        if (txen1) wq1.push_back(txd1);
        if (fd0) fdc0++;
        if (fd1) fdc1++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outcome derived from the frame fields alone.
    task automatic check_inst(input int i, input logic [7:0] q [$], input int base, input int fdd,
                              input logic [3:0] e, input logic [15:0] dlo, input logic [15:0] spo,
                              input logic [15:0] dpo, input logic [15:0] okc, input logic [15:0] drc);
        int dl, lim, nw;
        bit le, pe, tr, ov;
        logic [3:0] xe;
        dl  = (f_len < 16'd8) ? 0 : int'(f_len) - 8;
        le  = (f_len < 16'd8) || (dl > MAXD);
        pe  = (i == 0) && (f_dst != LP);
        tr  = !le && (f_npay < dl);
        lim = (f_npay < dl) ? f_npay : dl;
        ov  = !pe && !le && (f_full < lim);
        nw  = (pe || le) ? 0 : ((f_full < lim) ? f_full : lim);
        xe  = {tr, ov, le, pe};
        if (xe == 4'd0) ok_m[i]++;
        else            drop_m[i]++;
        chk($sformatf("wr_cnt%0d", i), 32'(q.size() - base), 32'(nw));
        for (int k = 0; k < nw && base + k < q.size(); k++) begin
            chk($sformatf("wr_byte%0d[%0d]", i, k), 32'(q[base + k]), 32'(cur_pay[k]));
        end
        chk($sformatf("err%0d", i), 32'(e), 32'(xe));
        chk($sformatf("dlen%0d", i), 32'(dlo), 32'(16'(dl)));
        chk($sformatf("src%0d", i), 32'(spo), 32'(f_src));
        chk($sformatf("det%0d", i), 32'(dpo), 32'(f_dst));
        chk($sformatf("fd%0d", i), 32'(fdd > 0), 32'(!tr));
        if (f_gap >= 3) begin
            chk($sformatf("ok_cnt%0d", i), 32'(okc), 32'(ok_m[i]));
            chk($sformatf("drop_cnt%0d", i), 32'(drc), 32'(drop_m[i]));
        end
    endtask

    task automatic run_frame(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                             input int npay, input int full_at, input bit seq,
                             input int gap, input int rst_at);
        logic [7:0] hdr [8];
        int b0, b1, c0, c1;
        hdr[0] = src[15:8]; hdr[1] = src[7:0];
        hdr[2] = dst[15:8]; hdr[3] = dst[7:0];
        hdr[4] = len[15:8]; hdr[5] = len[7:0];
        hdr[6] = 8'($urandom); hdr[7] = 8'($urandom);
        f_src = src; f_dst = dst; f_len = len;
        f_npay = npay; f_full = full_at; f_gap = gap;
        cur_pay.delete();
        for (int i = 0; i < npay; i++) cur_pay.push_back(seq ? 8'(i) : 8'($urandom));
        b0 = wq0.size(); b1 = wq1.size(); c0 = fdc0; c1 = fdc1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            fs = 1'b1; rxd = hdr[i]; fifo_full = 1'b0;
        end
        for (int i = 0; i < npay; i++) begin
            @(posedge clk); #1;
            if (i == rst_at) begin
                rst = 1'b0; fs = 1'b0; fifo_full = 1'b0; rxd = 8'd0;
                #1;
                chk("rst_fd", 32'(fd0), 32'd0);
                chk("rst_err", 32'(err0), 32'd0);
                chk("rst_dlen", 32'(dlen0), 32'd0);
                chk("rst_src", 32'(src0), 32'd0);
                chk("rst_det", 32'(det0), 32'd0);
                chk("rst_txen", 32'(txen0), 32'd0);
                chk("rst_ok", 32'(ok0), 32'd0);
                chk("rst_drop", 32'(drop0), 32'd0);
                chk("rst_ok1", 32'(ok1), 32'd0);
                ok_m   = '{0, 0};
                drop_m = '{0, 0};
                @(posedge clk); #1;
                rst = 1'b1;
                return;
            end
            fs = 1'b1; rxd = cur_pay[i]; fifo_full = (i >= full_at);
        end
        @(posedge clk); #1;
        fs = 1'b0; fifo_full = 1'b0; rxd = 8'd0;
        repeat (gap - 1) @(posedge clk);
        @(negedge clk); #1;
        check_inst(0, wq0, b0, fdc0 - c0, err0, dlen0, src0, det0, ok0, drop0);
        check_inst(1, wq1, b1, fdc1 - c1, err1, dlen1, src1, det1, ok1, drop1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [15:0] r_dst, r_len;
        int r_full;
        ok_m   = '{0, 0};
        drop_m = '{0, 0};
        repeat (3) @(posedge clk);
        #1;
        chk("reset_fd", 32'(fd0), 32'd0);
        chk("reset_txen", 32'(txen0), 32'd0);
        chk("reset_txd", 32'(txd0), 32'd0);
        chk("reset_err", 32'(err0), 32'd0);
        chk("reset_dlen", 32'(dlen0), 32'd0);
        chk("reset_src", 32'(src0), 32'd0);
        chk("reset_det", 32'(det0), 32'd0);
        chk("reset_ok", 32'(ok0), 32'd0);
        chk("reset_drop", 32'(drop0), 32'd0);
        rst = 1'b1;
        @(posedge clk);

        // good frame, sequential payload
        run_frame(16'h1234, LP, 16'h0028, 32, BIG, 1'b1, 4, -1);
        // port mismatch: dropped by filtering instance, accepted by the other
        run_frame(16'hABCD, 16'h1F91, 16'h0028, 32, BIG, 1'b0, 4, -1);
        // length below header size, then length above MAX_DLEN
        run_frame(16'h0001, LP, 16'h0006, 4, BIG, 1'b0, 4, -1);
        run_frame(16'h0002, LP, 16'h05E0, 5, BIG, 1'b0, 4, -1);
        // downstream full from payload byte 10
        run_frame(16'h0003, LP, 16'h0028, 32, 10, 1'b1, 4, -1);
        // truncated after 20 payload bytes, then a good frame
        run_frame(16'h0004, LP, 16'h0028, 20, BIG, 1'b1, 4, -1);
        run_frame(16'h0005, LP, 16'h0028, 32, BIG, 1'b0, 4, -1);

        for (int r = 0; r < 8; r++) begin
            r_dst  = ($urandom_range(0, 1) == 0) ? LP : 16'($urandom);
            r_len  = 16'(8 + $urandom_range(0, 40));
            r_full = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(r_len) - 8)) : BIG;
            run_frame(16'($urandom), r_dst, r_len, int'(r_len) - 8, r_full, 1'b0, 4, -1);
        end

        // back-to-back frames with 1-cycle gaps, reset during the third
        run_frame(16'h0101, LP, 16'h0028, 32, BIG, 1'b0, 1, -1);
        run_frame(16'h0202, LP, 16'h0028, 32, BIG, 1'b0, 1, -1);
        run_frame(16'h0303, LP, 16'h0028, 32, BIG, 1'b0, 1, 15);
        run_frame(16'h0404, LP, 16'h0028, 32, BIG, 1'b0, 4, -1);
        chk("final_ok_cnt", 32'(ok0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/udp_rx_filt.md
# udp_rx_filt

Parametrised UDP receive parser with destination-port filtering, length validation, FIFO back-pressure detection and frame statistics. It replaces the fixed `udp_rx` on the Ethernet receive path. It takes the byte stream from the IP layer under the `fs`/`fd` handshake, extracts the 8-byte UDP header, and writes only accepted payload bytes into the downstream `fifo_eth`. It flags and counts rejected or damaged frames.

## Interface
- `LOCAL_PORT`, 16'h1F90: destination port that is accepted.
- `PORT_FILT`, 1: 1 = drop frames whose destination port differs from `LOCAL_PORT`; 0 = accept any port.
- `MAX_DLEN`, 1472: largest payload length accepted, in bytes.
- `CNT_W`, 16: width of the statistics counters.

- `clk`, in, 1: single clock for the whole block.
- `rst`, in, 1: asynchronous, active-low reset.
- `fs`, in, 1: frame start. Rises with header byte 0 on `rxd`, then stays high while bytes stream at 1 byte/cycle.
- `rxd`, in, 8: frame byte.
- `fifo_full`, in, 1: full flag from the downstream FIFO.
- `fd`, out, 1: frame done, for accepted or dropped frames.
- `dlen`, out, 16: payload length (UDP length − 8).
- `src_ip_port`, out, 16: captured source port.
- `det_ip_port`, out, 16: captured destination port.
- `fifo_txen`, out, 1: payload write strobe.
- `fifo_txd`, out, 8: payload byte.
- `err`, out, 4: sticky for the current frame. Bit 0 = port mismatch, bit 1 = bad length, bit 2 = FIFO overflow, bit 3 = truncated.
- `frm_ok_cnt`, out, CNT_W: count of accepted frames.
- `frm_drop_cnt`, out, CNT_W: count of dropped or errored frames.

## Operation
- Header is big-endian. Bytes 0–1 are the source port, 2–3 the destination port, 4–5 the length, 6–7 the checksum. The checksum is captured and ignored.
- States:
  - IDLE: `fs` high moves to HDR with byte 0 consumed. Header counter is 3 bits, 0..7.
  - HDR: port checked at byte 3, length at byte 5. At byte 7 the next state is decided:
    - any error → DROP;
    - dlen = 0 → DONE;
    - otherwise → DATA.
  - DATA: each cycle writes `rxd` to the FIFO. A 16-bit payload counter compares against `dlen`; after the dlen-th byte the next state is DONE.
  - DROP: consumes the remaining dlen bytes with no writes, then moves to DONE. If length is invalid, DROP waits for `fs` low instead.
  - DONE: `fd`=1, held until `fs` is low, then IDLE.
- Length is bad when the length field is < 8, or when dlen > `MAX_DLEN`. dlen = len − 8, 16-bit unsigned, computed only after the < 8 check.
- Overflow: `fifo_full`=1 on a DATA cycle sets err[2]. That byte and all later bytes are not written; the block continues in DATA and counts bytes to the frame end.
- Truncation: `fs` low in HDR, DATA or DROP sets err[3]. The block counts the frame as dropped and returns to IDLE with no `fd`.
- Counters:
  - At DONE entry, the frame adds 1 to `frm_ok_cnt` if err = 0, otherwise 1 to `frm_drop_cnt`.
  - A truncated frame adds 1 to `frm_drop_cnt`.
  - Both counters saturate at all-ones.
- `err`, the ports and `dlen` are cleared on IDLE→HDR and are stable from DONE until the next frame.
- Reset values: every output is 0 and the state is IDLE. A reset mid-frame discards the frame; counters are not incremented.

## Timing
- Payload latency: `fifo_txen`/`fifo_txd` are registered, appearing 1 cycle after the byte is on `rxd`.
- `dlen`, `src_ip_port` and `det_ip_port` are valid from the cycle after header byte 7.
- `fd` rises 1 cycle after the last payload byte, or after header byte 7 when dlen = 0.
- Back-to-back frames: `fs` may rise again on the cycle after `fd` has been seen with `fs` low. The minimum gap is 1 idle cycle.
- `fs` staying high past the last byte is legal; `fd` simply stays high.
- `fifo_full` is sampled in the same cycle as the byte it would gate.

## Structure
- Package `udp_pkg` holds:
  - state encodings IDLE, HDR, DATA, DROP, DONE (8-bit, matching the team's localparam style);
  - `UDP_HDR_LEN` = 8;
  - header byte offsets;
  - err bit indices.
- Sub-module `sat_cnt` (parameter width, inputs inc and clear, saturating) is instantiated twice, once per statistics counter.

## Test plan
- Port 0x1F90, length 0x0028, 32 payload bytes 0x00..0x1F → 32 writes in order, `dlen`=0x0020, `fd` pulses, err=0, `frm_ok_cnt`=1.
- Destination port 0x1F91 with `PORT_FILT`=1 → 0 writes, err=4'b0001, `fd` asserted, `frm_drop_cnt`=1. Same frame with `PORT_FILT`=0 → 32 writes and accepted.
- Length 0x0006 → err[1] set, no writes, `fd` after `fs` falls. Length 0x05E0 with `MAX_DLEN`=1472 → err[1] set.
- `fifo_full` raised at payload byte 10 of 32 → exactly 10 writes, err[2] set, `fd` at the frame end, `frm_drop_cnt`=1.
- `fs` dropped after payload byte 20 → err[3] set, no `fd`, back to IDLE. A following good frame is accepted normally.
- Four 32-byte frames with 1-cycle gaps, with `rst` pulsed low during the third frame's payload → outputs zeroed and the third frame discarded. The fourth frame is accepted, leaving `frm_ok_cnt`=1.
